// File: rtl/demux1to4_stream.sv
// One-entry buffered 1-to-4 stream demultiplexer with valid/ready handshakes.
// Optional per-destination delivery counters when DEMUX_CNT_EN is defined.
module demux1to4_stream #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
`ifdef DEMUX_CNT_EN
    input  logic             cnt_clr,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1,
    output logic [15:0]      cnt2,
    output logic [15:0]      cnt3,
`endif
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       sel_q;
    logic             accept;
    logic             deliver;

    // Buffer slot frees up in the same cycle its word is taken downstream.
    assign in_ready = (state == EMPTY) || out_ready[sel_q];
    assign accept   = in_valid && in_ready;
    assign deliver  = (state == FULL) && out_ready[sel_q];
    assign out_data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 4'b0000;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                out_valid[sel_q] = 1'b1;
                if (deliver && !accept) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= 2'd0;
        end else if (accept) begin
            data_q <= in_data;
            sel_q  <= sel;
        end
    end

`ifdef DEMUX_CNT_EN
    logic [15:0] cnt_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 16'd0;
            end
        end else if (cnt_clr) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 16'd0;
            end
        end else if (deliver && (cnt_q[sel_q] != 16'hFFFF)) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + 16'd1;
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed self-checking bench for demux1to4_stream.
// Counter scenarios run only when DEMUX_CNT_EN is defined.
module tb_demux1to4_stream;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef DEMUX_CNT_EN
    logic             cnt_clr;
    logic [15:0]      cnt0;
    logic [15:0]      cnt1;
    logic [15:0]      cnt2;
    logic [15:0]      cnt3;
`endif

    int checks;
    int errors;

    demux1to4_stream #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DEMUX_CNT_EN
        .cnt_clr   (cnt_clr),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3),
`endif
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        sel       = 2'd0;
        out_ready = 4'b0000;
`ifdef DEMUX_CNT_EN
        cnt_clr   = 1'b0;
`endif
        #3;
        checks++;
        if (out_valid !== 4'b0000 || in_ready !== 1'b1 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_init: out_valid=%b in_ready=%b out_data=%h want 0000 1 00000000",
                     out_valid, in_ready, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        sel      = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0100 || out_data !== 32'hDEADBEEF || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_full: out_valid=%b out_data=%h in_ready=%b want 0100 deadbeef 0",
                     out_valid, out_data, in_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0000 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b out_data=%h in_ready=%b want 0000 00000000 1",
                     out_valid, out_data, in_ready);
        end
`ifdef DEMUX_CNT_EN
        checks++;
        if (cnt2 !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: cnt2=%0d want 0", cnt2);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_routing();
        logic [3:0]       exp_v;
        logic [WIDTH-1:0] exp_d;
        out_ready = 4'b1111;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_v = 4'b0001 << (i - 1);
                exp_d = 32'h11111111 * i;
                checks++;
                if (out_valid !== exp_v || out_data !== exp_d || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL route_%0d: out_valid=%b out_data=%h in_ready=%b want %b %h 1",
                             i - 1, out_valid, out_data, in_ready, exp_v, exp_d);
                end
            end
            if (i < 4) begin
                in_valid = 1'b1;
                in_data  = 32'h11111111 * (i + 1);
                sel      = 2'(i);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL route_drain: out_valid=%b want 0000", out_valid);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5A5A5;
        sel       = 2'd1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 4'b1101;
            in_data   = 32'h5A5A5A5A;
            sel       = 2'd3;
            #1;
            checks++;
            if (out_valid !== 4'b0010 || in_ready !== 1'b0 || out_data !== 32'hA5A5A5A5) begin
                errors++;
                $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b out_data=%h want 0010 0 a5a5a5a5",
                         c, out_valid, in_ready, out_data);
            end
        end
        @(negedge clk);
        out_ready = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0010", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b1000 || out_data !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL bp_next: out_valid=%b out_data=%h want 1000 5a5a5a5a", out_valid, out_data);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%b want 0000", out_valid);
        end
    endtask

    task automatic test_idle();
        in_valid  = 1'b0;
        in_data   = 'x;
        sel       = 'x;
        out_ready = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 4'b0000 || in_ready !== 1'b1 || out_data !== 32'h5A5A5A5A) begin
                errors++;
                $display("FAIL idle_%0d: out_valid=%b in_ready=%b out_data=%h want 0000 1 5a5a5a5a",
                         c, out_valid, in_ready, out_data);
            end
        end
        in_data = '0;
        sel     = 2'd0;
    endtask

`ifdef DEMUX_CNT_EN
    task automatic test_counters();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr  = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hC0C0C0C0;
        sel      = 2'd3;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt3 !== 16'd3 || cnt0 !== 16'd0 || cnt1 !== 16'd0 || cnt2 !== 16'd0) begin
            errors++;
            $display("FAIL cnt_three: cnt0..3=%0d %0d %0d %0d want 0 0 0 3",
                     cnt0, cnt1, cnt2, cnt3);
        end
        in_valid = 1'b1;
        sel      = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checks++;
        if (cnt0 !== 16'd0 || cnt1 !== 16'd0 || cnt2 !== 16'd0 || cnt3 !== 16'd0) begin
            errors++;
            $display("FAIL cnt_clr_prio: cnt0..3=%0d %0d %0d %0d want 0 0 0 0",
                     cnt0, cnt1, cnt2, cnt3);
        end
        in_valid = 1'b1;
        sel      = 2'd1;
        repeat (65535) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt1 !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_full: cnt1=%h want ffff", cnt1);
        end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt1 !== 16'hFFFF || out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL cnt_sat: cnt1=%h out_valid=%b want ffff 0000", cnt1, out_valid);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_routing();
        test_backpressure();
        test_idle();
`ifdef DEMUX_CNT_EN
        test_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux1to4_stream.md
DEMUX1TO4_STREAM -- requirements
Module: demux1to4_stream

Interface
REQ-001 SHALL have parameter: WIDTH, 32, data path width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  upstream word present.
REQ-005 SHALL have port: in_ready  output  1  block accepts the word this cycle.
REQ-006 SHALL have port: in_data  input  WIDTH  upstream word.
REQ-007 SHALL have port: sel  input  2  destination index 0..3, sampled with in_data.
REQ-008 SHALL have port: out_valid  output  4  one-hot (or zero) destination valid; bit i maps to destination i.
REQ-009 SHALL have port: out_ready  input  4  per-destination ready; bit i maps to destination i.
REQ-010 SHALL have port: out_data  output  WIDTH  held word, broadcast to all four destinations.
REQ-011 SHALL have ports (only with DEMUX_CNT_EN): cnt_clr  input  1  synchronous counter clear; cnt0..cnt3  output  16 each  per-destination delivery counts.

Function
REQ-012 SHALL implement a one-entry holding buffer: state EMPTY or FULL, registers data_q[WIDTH-1:0] and sel_q[1:0].
REQ-013 SHALL drive in_ready = (state==EMPTY) || out_ready[sel_q], combinationally.
REQ-014 SHALL accept a word when in_valid && in_ready, loading data_q<=in_data and sel_q<=sel at that edge.
REQ-015 SHALL drive out_valid[i] = (state==FULL) && (sel_q==i); never more than one bit high.
REQ-016 SHALL drive out_data = data_q at all times.
REQ-017 SHALL complete a delivery when out_valid[sel_q] && out_ready[sel_q].
REQ-018 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on delivery without accept; stay FULL on delivery plus accept (new word loaded same edge); stay FULL when not delivered.
REQ-019 SHALL give latency of one cycle: a word accepted at edge k is valid at its destination from edge k until delivered.
REQ-020 SHALL sustain one word per cycle when the addressed out_ready is held high, including consecutive words to different destinations.
REQ-021 SHALL keep data_q, sel_q and out_valid stable while FULL and out_ready[sel_q] is low; ready of non-addressed destinations SHALL be ignored.
REQ-022 SHALL ignore in_data and sel (including X) when in_valid is low.
REQ-023 SHALL keep out_valid from depending combinationally on out_ready or in_valid.

Reset
REQ-024 SHALL on rst_n low, immediately and regardless of clk: state=EMPTY, data_q=0, sel_q=0, out_valid=4'b0000, in_ready=1, out_data=0, counters=0.
REQ-025 SHALL discard a held undelivered word when reset asserts mid-operation; no delivery SHALL be counted for it.
REQ-026 SHALL resume accepting on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL with macro DEMUX_CNT_EN defined: add the cnt_clr and cnt0..cnt3 ports; increment cnt[i] on each delivery to destination i; saturate at 16'hFFFF; cnt_clr clears all four and has priority over increment in the same cycle.
REQ-028 SHALL with DEMUX_CNT_EN undefined: omit those ports and counter logic; all other behaviour identical.

Verification
REQ-029 SHALL verify reset: rst_n=0 mid-FULL (data 32'hDEADBEEF, sel=2) -> out_valid=0000, out_data=0, in_ready=1 without a clock edge.
REQ-030 SHALL verify routing: send 32'h11111111..32'h44444444 with sel=0..3, out_ready=1111 -> out_valid 0001,0010,0100,1000 on consecutive cycles, with the matching data each cycle.
REQ-031 SHALL verify backpressure: sel=1, data 32'hA5A5A5A5, out_ready=1101 for 3 cycles -> out_valid=0010 held, in_ready=0, data stable; out_ready[1]=1 -> delivered, next word accepted same edge.
REQ-032 SHALL verify idle: in_valid=0 with sel=X and data=X for 5 cycles -> state stays EMPTY, out_valid=0000.
REQ-033 SHALL verify counters (DEMUX_CNT_EN): 3 deliveries to destination 3 -> cnt3=3, others 0; cnt_clr asserted with a simultaneous delivery -> all 0; preload to 16'hFFFF plus one more delivery -> stays 16'hFFFF.
